// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared brightness width, full-on/off levels and saturating step helper
//   BRI_W    brightness width in bits
//   BRI_ON   full-on brightness level
//   BRI_OFF  full-off brightness level
//   sat_step move a brightness toward on/off by a step, clamping at the ends
package led_fader_pkg;
   localparam int BRI_W = 8;
   localparam logic [BRI_W-1:0] BRI_ON = {BRI_W{1'b1}};
   localparam logic [BRI_W-1:0] BRI_OFF = '0;
   function automatic logic [BRI_W-1:0] sat_step(input logic [BRI_W-1:0] b, input logic up,
                                                 input logic [BRI_W-1:0] s);
      logic [BRI_W:0] sum;
      sum = {1'b0, b} + {1'b0, s};
      return up ? (sum[BRI_W] ? BRI_ON : sum[BRI_W-1:0]) : (b < s ? BRI_OFF : b - s);
   endfunction
endpackage

// File: rtl/led_fader_chan.sv
// led_fader_chan: one LED channel -- brightness register, saturating fade step, PWM comparator
//   clk, reset   clock and async active-low reset
//   bypass       snap brightness straight to gpio_bit
//   frame_end    fade step strobe
//   gpio_bit     level being captured as the new target this cycle
//   tgt_bit      currently latched target level
//   cnt          shared PWM counter
//   led_d        next-state PWM output
//   settled      brightness has reached the latched target level
module led_fader_chan
   import led_fader_pkg::*;
#(
   parameter int STEP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bypass,
   input  logic             frame_end,
   input  logic             gpio_bit,
   input  logic             tgt_bit,
   input  logic [BRI_W-1:0] cnt,
   output logic             led_d,
   output logic             settled
);
   localparam logic [BRI_W-1:0] STEP_L = BRI_W'(STEP);
   logic [BRI_W-1:0] bri_q, bri_d;
   always_comb begin
      bri_d = bypass ? (gpio_bit ? BRI_ON : BRI_OFF)
            : frame_end ? sat_step(bri_q, gpio_bit, STEP_L) : bri_q;
      // full-on is forced high so 255 gives a constant 1 rather than 255/256 duty
      led_d = (bri_q == BRI_ON) || (cnt < bri_q);
      settled = tgt_bit ? (bri_q == BRI_ON) : (bri_q == BRI_OFF);
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) bri_q <= BRI_OFF;
      else bri_q <= bri_d;
endmodule

// File: rtl/led_fader.sv
// led_fader: 8-channel LED PWM fader with frame-synchronous targets and a direct bypass
//   clk, reset    clock and async active-low reset
//   gpio_in       LED target byte
//   bypass        drive LEDs directly from gpio_in
//   led_out       registered PWM LED drive
//   frame_strobe  one-cycle pulse after each PWM frame end
//   busy          some channel has not reached its latched target
module led_fader
   import led_fader_pkg::*;
#(
   parameter int PRESCALE = 4,
   parameter int STEP = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] gpio_in,
   input  logic       bypass,
   output logic [7:0] led_out,
   output logic       frame_strobe,
   output logic       busy
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q, pre_d;
   logic [BRI_W-1:0] cnt_q, cnt_d;
   logic [7:0] tgt_q, tgt_d, led_q, led_d, led_pwm, settled;
   logic strobe_q, strobe_d, busy_q, busy_d, tick, frame_end;
   always_comb begin
      tick = pre_q == PW'(PRESCALE - 1);
      frame_end = tick && cnt_q == BRI_ON;
      pre_d = tick ? '0 : pre_q + PW'(1);
      cnt_d = tick ? cnt_q + BRI_W'(1) : cnt_q;
      strobe_d = frame_end;
      // bypass overrides frame capture, so a coinciding frame end changes nothing extra
      tgt_d = (bypass || frame_end) ? gpio_in : tgt_q;
      led_d = bypass ? gpio_in : led_pwm;
      busy_d = ~&settled;
   end
   for (genvar i = 0; i < 8; i++) begin : g_chan
      led_fader_chan #(.STEP(STEP)) u_chan (
         .clk      (clk),
         .reset    (reset),
         .bypass   (bypass),
         .frame_end(frame_end),
         .gpio_bit (gpio_in[i]),
         .tgt_bit  (tgt_q[i]),
         .cnt      (cnt_q),
         .led_d    (led_pwm[i]),
         .settled  (settled[i])
      );
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pre_q <= '0;
         cnt_q <= '0;
         tgt_q <= '0;
         led_q <= '0;
         strobe_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
         tgt_q <= tgt_d;
         led_q <= led_d;
         strobe_q <= strobe_d;
         busy_q <= busy_d;
      end
   assign led_out = led_q;
   assign frame_strobe = strobe_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed checks of two led_fader builds (PRESCALE=1/STEP=64 and PRESCALE=2/STEP=255)
module tb_led_fader;
   logic clk = 1'b0;
   logic reset;
   logic [7:0] gpio;
   logic bypass;
   logic [7:0] led_a, led_b;
   logic strobe_a, strobe_b, busy_a, busy_b;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   typedef struct {
      logic       byp;
      logic [7:0] gpio;
      int         cycles;
      logic [7:0] exp_led;
   } vec_t;
   vec_t tbl[7];
   always #5 clk = ~clk;
   led_fader #(.PRESCALE(1), .STEP(64)) dut_a (
      .clk(clk), .reset(reset), .gpio_in(gpio), .bypass(bypass),
      .led_out(led_a), .frame_strobe(strobe_a), .busy(busy_a)
   );
   led_fader #(.PRESCALE(2), .STEP(255)) dut_b (
      .clk(clk), .reset(reset), .gpio_in(gpio), .bypass(bypass),
      .led_out(led_b), .frame_strobe(strobe_b), .busy(busy_b)
   );
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask
   task automatic check_strobes();
      check("strobe_a", {7'b0, strobe_a}, {7'b0, cyc % 256 == 0});
      check("strobe_b", {7'b0, strobe_b}, {7'b0, cyc % 512 == 0});
   endtask
   initial begin
      int na, ba, ca, nb, cb, bb, hi1, hi2;
      logic [7:0] prev;
      tbl[0] = '{1'b1, 8'hA5, 300, 8'hA5};
      tbl[1] = '{1'b1, 8'h3C, 2, 8'h3C};
      tbl[2] = '{1'b1, 8'hFF, 3, 8'hFF};
      tbl[3] = '{1'b1, 8'h00, 2, 8'h00};
      tbl[4] = '{1'b1, 8'h5A, 2, 8'h5A};
      tbl[5] = '{1'b1, 8'hA5, 2, 8'hA5};
      tbl[6] = '{1'b0, 8'hA5, 600, 8'hA5};
      hi1 = 0;
      hi2 = 0;
      reset = 1'b0;
      gpio = 8'h01;
      bypass = 1'b0;
      step(3);
      check("rst_led_a", led_a, 8'h00);
      check("rst_led_b", led_b, 8'h00);
      check("rst_busy_a", {7'b0, busy_a}, 8'h00);
      check("rst_busy_b", {7'b0, busy_b}, 8'h00);
      check("rst_strobe_a", {7'b0, strobe_a}, 8'h00);
      check("rst_strobe_b", {7'b0, strobe_b}, 8'h00);
      reset = 1'b1;
      cyc = 0;
      // fade-in of channel 0 plus a mid-frame gpio glitch that must be ignored
      for (int k = 1; k <= 1400; k++) begin
         step(1);
         na = (k - 1) / 256;
         ba = (na * 64 > 255) ? 255 : na * 64;
         ca = (k - 1) % 256;
         nb = (k - 1) / 512;
         cb = ((k - 1) / 2) % 256;
         bb = nb >= 1 ? 255 : 0;
         check("fade_led_a", led_a, {7'b0, ba == 255 || ca < ba});
         check("fade_busy_a", {7'b0, busy_a}, {7'b0, k >= 257 && k <= 1024});
         check("fade_led_b", led_b, {7'b0, bb == 255 || cb < bb});
         check("fade_busy_b", {7'b0, busy_b}, 8'h00);
         check_strobes();
         if (k > 256 && k <= 512) hi1 += int'(led_a[0]);
         if (k > 512 && k <= 768) hi2 += int'(led_a[0]);
         if (k == 1379) gpio = 8'hFF;
         if (k == 1389) gpio = 8'h01;
      end
      check("duty_64", 8'(hi1), 8'd64);
      check("duty_128", 8'(hi2), 8'd128);
      // bypass vectors, then bypass release holding the snapped levels
      for (int v = 0; v < 7; v++) begin
         bypass = tbl[v].byp;
         gpio = tbl[v].gpio;
         for (int j = 0; j < tbl[v].cycles; j++) begin
            step(1);
            check("byp_led_a", led_a, tbl[v].exp_led);
            check("byp_led_b", led_b, tbl[v].exp_led);
            check("byp_busy_a", {7'b0, busy_a}, 8'h00);
            check("byp_busy_b", {7'b0, busy_b}, 8'h00);
            check_strobes();
         end
      end
      // STEP=255 build: full on/off jumps on alternate frames
      while (cyc % 512 != 0) step(1);
      check("align_strobe_b", {7'b0, strobe_b}, 8'h01);
      prev = 8'hA5;
      for (int r = 0; r < 4; r++) begin
         gpio = (r % 2 == 0) ? 8'hFF : 8'h00;
         for (int j = 1; j <= 512; j++) begin
            step(1);
            check("jump_led_b", led_b, prev);
            check("jump_busy_b", {7'b0, busy_b}, 8'h00);
            check_strobes();
         end
         prev = gpio;
      end
      // reset in the middle of a fade with channel 0 at brightness 128
      bypass = 1'b1;
      gpio = 8'h00;
      step(2);
      bypass = 1'b0;
      gpio = 8'h01;
      while (cyc < 5220) step(1);
      check("mid_led_a", led_a, 8'h01);
      check("mid_busy_a", {7'b0, busy_a}, 8'h01);
      #3;
      reset = 1'b0;
      #1;
      check("async_led_a", led_a, 8'h00);
      check("async_led_b", led_b, 8'h00);
      check("async_busy_a", {7'b0, busy_a}, 8'h00);
      check("async_strobe_a", {7'b0, strobe_a}, 8'h00);
      step(3);
      reset = 1'b1;
      cyc = 0;
      for (int k = 1; k <= 600; k++) begin
         step(1);
         check_strobes();
         if (k <= 256) check("post_busy_a", {7'b0, busy_a}, 8'h00);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter PRESCALE, default 4, clock cycles per PWM tick (legal range 1..65535).
REQ-002 Parameter STEP, default 1, brightness change per channel per PWM frame (legal range 1..255).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 gpio_in  input  8  LED target byte from the GPIO register; bit i=1 means channel i on.
REQ-006 bypass  input  1  1 = drive LEDs directly from gpio_in, no fading.
REQ-007 led_out  output  8  PWM-modulated LED drive, registered.
REQ-008 frame_strobe  output  1  one-cycle pulse at each PWM frame boundary.
REQ-009 busy  output  1  1 while any channel brightness differs from its latched target level.

Function
REQ-010 Prescaler counter pre SHALL count 0..PRESCALE-1 and wrap; tick SHALL be true in the cycle where pre==PRESCALE-1.
REQ-011 8-bit PWM counter cnt SHALL increment on tick only and wrap 255->0; frame length SHALL be 256*PRESCALE cycles.
REQ-012 Frame end SHALL be defined as tick && cnt==255; frame_strobe SHALL be registered high for exactly the cycle after the frame-end edge.
REQ-013 On the frame-end edge, target register tgt SHALL capture gpio_in; gpio_in changes between frame ends SHALL have no effect when bypass=0.
REQ-014 On the same edge, each brightness bri[i] (8-bit) SHALL move toward 255 if the newly captured tgt[i]=1, else toward 0, by STEP, saturating at 0/255 without wrap.
REQ-015 Next-state led_out[i] SHALL be 1 when bri[i]==255 or cnt<bri[i], else 0; bri[i]==0 SHALL give constant 0, bri[i]==255 SHALL give constant 1.
REQ-016 led_out SHALL be registered: one cycle latency from cnt/bri to pin.
REQ-017 busy SHALL be registered, 1 when any bri[i] is neither 255 with tgt[i]=1 nor 0 with tgt[i]=0.
REQ-018 bypass=1: every cycle tgt<=gpio_in, bri[i]<=tgt?255:0 of gpio_in, led_out<=gpio_in (one-cycle latency); prescaler, cnt and frame_strobe SHALL keep running.
REQ-019 bypass 1->0 SHALL resume fading from the snapped bri values with no glitch on led_out beyond normal PWM.
REQ-020 Frame end coinciding with bypass=1 SHALL follow REQ-018 (bypass wins).
REQ-021 No input handshake; gpio_in SHALL be treated as synchronous to clk.

Reset
REQ-022 While reset=0: pre=0, cnt=0, tgt=0x00, all bri=0, led_out=0x00, frame_strobe=0, busy=0.
REQ-023 Reset assertion mid-frame or mid-fade SHALL abandon all state immediately; first frame end after release occurs 256*PRESCALE cycles after the first active edge.

Structure
REQ-024 A shared package/header SHALL hold the brightness width (8) and the full-on/off constants (255/0).
REQ-025 One sub-module led_fader_chan (one bri register, saturating step, comparator) SHALL be instantiated 8 times; prescaler, cnt, tgt and strobe logic stay in the top.

Verification
REQ-026 PRESCALE=1, STEP=64, gpio_in=0x01 held from reset release -> frame_strobe every 256 cycles; bri[0] 64,128,192,255 after frames 1..4; busy falls after frame 4; led_out[0] then constant 1, led_out[7:1]=0.
REQ-027 With bri[0]=128 (PRESCALE=1) -> led_out[0] high exactly 128 of 256 cycles per frame, rising one cycle after cnt wraps to 0.
REQ-028 gpio_in pulsed 0x00->0xFF->0x00 for 10 cycles mid-frame, bypass=0 -> tgt and led_out unchanged, busy stays 0.
REQ-029 bypass=1, gpio_in=0xA5 -> led_out=0xA5 next cycle; bypass=0 -> duty stays 100%/0% per bit, busy=0.
REQ-030 Reset asserted during fade (bri[0]=128) -> led_out=0x00, busy=0 immediately (asynchronously); after release, frame_strobe first at cycle 256*PRESCALE.
REQ-031 STEP=255, toggle gpio_in 0xFF/0x00 every frame -> bri jumps 0->255->0 with no wrap, led_out fully on/off in alternate frames.
